// File: rtl/matrix_multiplication.sv
// matrix_multiplication: 4x4 int8 output-stationary systolic matmul tile, C = A x B.
// Operands stream from RAMs matrix_A/matrix_B; low result bytes are written to matrix_C.

module mm_ram #(
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = 11,
  parameter int MEM_SIZE = 2048,
  parameter int LANES    = 4
) (
  input  logic                       clk,
  input  logic [AWIDTH-1:0]          addr,
  input  logic [LANES-1:0]           we,
  input  logic [LANES-1:0][DWIDTH-1:0] wdata,
  output logic [LANES-1:0][DWIDTH-1:0] rdata
);
  logic [DWIDTH-1:0] ram [0:MEM_SIZE-1];

  // Byte lanes addr..addr+LANES-1; the index wraps at the top of the RAM.
  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (we[b]) ram[addr + AWIDTH'(b)] <= wdata[b];
      rdata[b] <= ram[addr + AWIDTH'(b)];
    end
  end
endmodule

module mm_pe #(
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic [DWIDTH-1:0] a_fwd,
  output logic [DWIDTH-1:0] b_fwd,
  output logic [DWIDTH-1:0] res
);
  logic [2*DWIDTH-1:0] acc, prod;

  // Sign-extend both operands so the low 2*DWIDTH bits are the signed product.
  assign prod = {{DWIDTH{a[DWIDTH-1]}}, a} * {{DWIDTH{b[DWIDTH-1]}}, b};
  assign res  = acc[DWIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      a_fwd <= '0;
      b_fwd <= '0;
    end else if (clr) begin
      acc   <= '0;
      a_fwd <= '0;
      b_fwd <= '0;
    end else begin
      acc   <= acc + prod;
      a_fwd <= a;
      b_fwd <= b;
    end
  end
endmodule

module matrix_multiplication #(
  parameter int DWIDTH       = 8,
  parameter int AWIDTH       = 11,
  parameter int MEM_SIZE     = 2048,
  parameter int MAT_MUL_SIZE = 4
) (
  input  logic                    clk,
  input  logic                    clk_mem,
  input  logic                    resetn,
  input  logic                    pe_resetn,
  input  logic [AWIDTH-1:0]       address_mat_a,
  input  logic [AWIDTH-1:0]       address_mat_b,
  input  logic [AWIDTH-1:0]       address_mat_c,
  input  logic [7:0]              address_stride_a,
  input  logic [7:0]              address_stride_b,
  input  logic [7:0]              address_stride_c,
  input  logic [MAT_MUL_SIZE-1:0] validity_mask_a_rows,
  input  logic [MAT_MUL_SIZE-1:0] validity_mask_a_cols_b_rows,
  input  logic [MAT_MUL_SIZE-1:0] validity_mask_b_cols,
  input  logic                    start_reg,
  input  logic                    clear_done_reg,
  output logic                    done_mat_mul
);
  localparam int N  = MAT_MUL_SIZE;
  localparam int KW = $clog2(N);

  typedef enum logic [1:0] {IDLE, COMPUTE, WRITE, DONE} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [AWIDTH-1:0] base_a, base_b, base_c, addr_a, addr_b, addr_c;
  logic [7:0]        stride_a, stride_b, stride_c;
  logic [N-1:0]      mask_row, mask_k, mask_col, we_c;
  logic              rd_vld, clr;
  logic [KW-1:0]     row, kidx;

  logic [N-1:0][DWIDTH-1:0]        rdata_a, rdata_b, feed_a, feed_b, wdata_c;
  logic [N-1:0][DWIDTH-1:0]        c_rdata_unused, a_edge_unused, b_edge_unused;
  logic [N-1:0][N-1:0][DWIDTH-1:0] a_h, b_v, res;

  assign clr    = (state == IDLE) && start_reg && !done_mat_mul;
  assign row    = cnt[KW-1:0];
  assign kidx   = cnt[KW-1:0] - KW'(1);
  assign addr_a = base_a + AWIDTH'(kidx) * AWIDTH'(stride_a);
  assign addr_b = base_b + AWIDTH'(kidx) * AWIDTH'(stride_b);
  assign addr_c = base_c + AWIDTH'(row) * AWIDTH'(stride_c);
  assign we_c   = (state == WRITE && mask_row[row]) ? mask_col : '0;
  assign wdata_c = res[row];
  // Masked-off reduction steps feed zeros, so they contribute nothing.
  assign feed_a = rd_vld ? rdata_a : '0;
  assign feed_b = rd_vld ? rdata_b : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= '0;
      done_mat_mul <= 1'b0;
      rd_vld       <= 1'b0;
      base_a       <= '0;
      base_b       <= '0;
      base_c       <= '0;
      stride_a     <= '0;
      stride_b     <= '0;
      stride_c     <= '0;
      mask_row     <= '0;
      mask_k       <= '0;
      mask_col     <= '0;
    end else begin
      // Reads for k=0..N-1 are issued at cnt=1..N; data lands one cycle later.
      rd_vld <= (state == COMPUTE) && (cnt >= 4'd1) && (cnt <= 4'(N)) && mask_k[kidx];
      case (state)
        IDLE: if (clr) begin
          state    <= COMPUTE;
          cnt      <= '0;
          base_a   <= address_mat_a;
          base_b   <= address_mat_b;
          base_c   <= address_mat_c;
          stride_a <= address_stride_a;
          stride_b <= address_stride_b;
          stride_c <= address_stride_c;
          mask_row <= validity_mask_a_rows;
          mask_k   <= validity_mask_a_cols_b_rows;
          mask_col <= validity_mask_b_cols;
        end
        // Last product reaches PE[N-1][N-1] at cnt = 3N-1.
        COMPUTE: if (cnt == 4'(3*N-1)) begin
          state <= WRITE;
          cnt   <= '0;
        end else cnt <= cnt + 4'd1;
        WRITE: if (cnt == 4'(N-1)) begin
          state        <= DONE;
          cnt          <= '0;
          done_mat_mul <= 1'b1;
        end else cnt <= cnt + 4'd1;
        DONE: if (clear_done_reg && !start_reg) begin
          state        <= IDLE;
          done_mat_mul <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  mm_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE), .LANES(N)) matrix_A (
    .clk(clk_mem), .addr(addr_a), .we('0), .wdata('0), .rdata(rdata_a));
  mm_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE), .LANES(N)) matrix_B (
    .clk(clk_mem), .addr(addr_b), .we('0), .wdata('0), .rdata(rdata_b));
  mm_ram #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .MEM_SIZE(MEM_SIZE), .LANES(N)) matrix_C (
    .clk(clk_mem), .addr(addr_c), .we(we_c), .wdata(wdata_c), .rdata(c_rdata_unused));

  // Row i of A and column i of B enter the array i cycles late (wavefront skew).
  for (genvar i = 0; i < N; i++) begin : g_skew
    if (i == 0) begin : g_direct
      assign a_h[0][0] = feed_a[0];
      assign b_v[0][0] = feed_b[0];
    end else begin : g_dly
      logic [i-1:0][DWIDTH-1:0] sa, sb;
      always_ff @(posedge clk or negedge pe_resetn) begin
        if (!pe_resetn) begin
          sa <= '0;
          sb <= '0;
        end else if (clr) begin
          sa <= '0;
          sb <= '0;
        end else begin
          sa[0] <= feed_a[i];
          sb[0] <= feed_b[i];
          for (int d = 1; d < i; d++) begin
            sa[d] <= sa[d-1];
            sb[d] <= sb[d-1];
          end
        end
      end
      assign a_h[i][0] = sa[i-1];
      assign b_v[0][i] = sb[i-1];
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DWIDTH-1:0] a_nxt, b_nxt;
      mm_pe #(.DWIDTH(DWIDTH)) u_pe (
        .clk(clk), .rst_n(pe_resetn), .clr(clr), .a(a_h[i][j]), .b(b_v[i][j]),
        .a_fwd(a_nxt), .b_fwd(b_nxt), .res(res[i][j]));
      if (j < N-1) begin : g_ar
        assign a_h[i][j+1] = a_nxt;
      end else begin : g_ae
        assign a_edge_unused[i] = a_nxt;
      end
      if (i < N-1) begin : g_bd
        assign b_v[i+1][j] = b_nxt;
      end else begin : g_be
        assign b_edge_unused[j] = b_nxt;
      end
    end
  end
endmodule

// File: tb/tb_matrix_multiplication.sv
// Self-checking bench for matrix_multiplication: table of configurations plus random runs
// compared against a whole-memory reference model, and hand-written control sequences.

module tb_matrix_multiplication;
  localparam int MS = 2048;

  typedef struct {
    string       name;
    int          sel;      // 0 all ones, 1 example data, 2 random data
    logic [10:0] ba, bb, bc;
    logic [7:0]  sa, sb, sc;
    logic [3:0]  mr, mk, mc;
    bit          has_exp;
    logic [127:0] exp;     // C[0][0] in the top byte, row-major
  } vec_t;

  logic clk = 1'b0;
  logic resetn, pe_resetn, start_reg, clear_done_reg, done_mat_mul;
  logic [10:0] address_mat_a, address_mat_b, address_mat_c;
  logic [7:0]  address_stride_a, address_stride_b, address_stride_c;
  logic [3:0]  validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols;

  always #5 clk = ~clk;

  matrix_multiplication dut (
    .clk(clk), .clk_mem(clk), .resetn(resetn), .pe_resetn(pe_resetn),
    .address_mat_a(address_mat_a), .address_mat_b(address_mat_b), .address_mat_c(address_mat_c),
    .address_stride_a(address_stride_a), .address_stride_b(address_stride_b),
    .address_stride_c(address_stride_c),
    .validity_mask_a_rows(validity_mask_a_rows),
    .validity_mask_a_cols_b_rows(validity_mask_a_cols_b_rows),
    .validity_mask_b_cols(validity_mask_b_cols),
    .start_reg(start_reg), .clear_done_reg(clear_done_reg), .done_mat_mul(done_mat_mul));

  int tests = 0;
  int fails = 0;
  logic [7:0] model_c [MS];
  int ma [4][4];
  int mb [4][4];
  int ex_a [4][4] = '{'{8,4,6,8}, '{3,3,3,7}, '{5,2,1,6}, '{9,1,0,5}};
  int ex_b [4][4] = '{'{1,1,3,0}, '{0,1,4,3}, '{3,5,3,1}, '{9,6,3,2}};
  vec_t tbl [$];
  vec_t cur;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    cur = v;
    address_mat_a = v.ba;  address_mat_b = v.bb;  address_mat_c = v.bc;
    address_stride_a = v.sa; address_stride_b = v.sb; address_stride_c = v.sc;
    validity_mask_a_rows = v.mr;
    validity_mask_a_cols_b_rows = v.mk;
    validity_mask_b_cols = v.mc;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        case (v.sel)
          0: begin ma[i][k] = 1; mb[i][k] = 1; end
          1: begin ma[i][k] = ex_a[i][k]; mb[i][k] = ex_b[i][k]; end
          default: begin
            ma[i][k] = int'($urandom_range(0, 255)) - 128;
            mb[i][k] = int'($urandom_range(0, 255)) - 128;
          end
        endcase
      end
    // A column-major, B row-major; addresses wrap at the RAM size.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        dut.matrix_A.ram[(int'(v.ba) + k*int'(v.sa) + i) % MS] = 8'(ma[i][k]);
        dut.matrix_B.ram[(int'(v.bb) + i*int'(v.sb) + k) % MS] = 8'(mb[i][k]);
      end
  endtask

  // Reference: plain dot products over enabled k, low byte stored for enabled (i,j).
  task automatic model_run();
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++)
          if (cur.mk[k]) s += ma[i][k] * mb[k][j];
        if (cur.mr[i] && cur.mc[j])
          model_c[(int'(cur.bc) + i*int'(cur.sc) + j) % MS] = 8'(s);
      end
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    int fa = 0;
    for (int a = 0; a < MS; a++)
      if (dut.matrix_C.ram[a] !== model_c[a]) begin
        if (bad == 0) fa = a;
        bad++;
      end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s mem: %0d C bytes differ, first at 0x%0h got 0x%02h expected 0x%02h",
               name, bad, fa, dut.matrix_C.ram[fa], model_c[fa]);
    end
  endtask

  task automatic check_exp(input vec_t v);
    int bad = 0;
    int fn = 0;
    logic [7:0] got, want;
    for (int n = 0; n < 16; n++) begin
      want = v.exp[127-8*n -: 8];
      got  = dut.matrix_C.ram[(int'(v.bc) + (n/4)*int'(v.sc) + n%4) % MS];
      if (got !== want) begin
        if (bad == 0) fn = n;
        bad++;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s C[%0d][%0d]: got 0x%02h expected 0x%02h (%0d bytes wrong)", v.name,
               fn/4, fn%4, dut.matrix_C.ram[(int'(v.bc) + (fn/4)*int'(v.sc) + fn%4) % MS],
               v.exp[127-8*fn -: 8], bad);
    end
  endtask

  // Call right after the edge that samples start; expects done exactly 16 edges later.
  task automatic wait_done(input string name);
    int lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (done_mat_mul) begin
        lat = n;
        break;
      end
    end
    check({name, " latency"}, lat, 16);
  endtask

  task automatic run_once(input string name);
    @(negedge clk); start_reg = 1'b1; clear_done_reg = 1'b0;
    @(posedge clk);
    wait_done(name);
    @(negedge clk); start_reg = 1'b0; clear_done_reg = 1'b1;
    @(posedge clk); #1;
    check({name, " done clear"}, int'(done_mat_mul), 0);
    @(negedge clk); clear_done_reg = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int seen;
    resetn = 1'b0; pe_resetn = 1'b0; start_reg = 1'b0; clear_done_reg = 1'b0;
    address_mat_a = '0; address_mat_b = '0; address_mat_c = '0;
    address_stride_a = '0; address_stride_b = '0; address_stride_c = '0;
    validity_mask_a_rows = '0; validity_mask_a_cols_b_rows = '0; validity_mask_b_cols = '0;
    for (int a = 0; a < MS; a++) begin
      model_c[a] = 8'($urandom);
      dut.matrix_C.ram[a] = model_c[a];
    end
    repeat (3) @(posedge clk);
    #1 check("reset done", int'(done_mat_mul), 0);
    @(negedge clk); resetn = 1'b1; pe_resetn = 1'b1;

    tbl.push_back('{"all_ones", 0, 11'h0, 11'h0, 11'h0, 8'd4, 8'd4, 8'd4, 4'hF, 4'hF, 4'hF,
                    1'b1, 128'h04040404_04040404_04040404_04040404});
    tbl.push_back('{"example", 1, 11'h0, 11'h0, 11'h0, 8'd4, 8'd4, 8'd4, 4'hF, 4'hF, 4'hF,
                    1'b1, 128'h625A5222_4B3F331A_3E302C13_36282E0D});
    tbl.push_back('{"kmask_0011", 1, 11'h0, 11'h0, 11'h0, 8'd4, 8'd4, 8'd4, 4'hF, 4'h3, 4'hF,
                    1'b1, 128'h080C280C_03061509_05071706_090A1F03});
    tbl.push_back('{"rc_mask_0001", 1, 11'h0, 11'h0, 11'h0, 8'd4, 8'd4, 8'd4, 4'h1, 4'hF, 4'h1,
                    1'b1, 128'h620C280C_03061509_05071706_090A1F03});
    tbl.push_back('{"strided", 1, 11'h100, 11'h200, 11'h300, 8'd8, 8'd8, 8'd16, 4'hF, 4'hF, 4'hF,
                    1'b1, 128'h625A5222_4B3F331A_3E302C13_36282E0D});
    for (int r = 0; r < 8; r++) begin
      v.name = $sformatf("rand%0d", r);
      v.sel = 2;
      v.ba = 11'($urandom_range(0, MS-1));
      v.bb = 11'($urandom_range(0, MS-1));
      v.bc = 11'($urandom_range(0, MS-1));
      v.sa = 8'($urandom_range(4, 255));
      v.sb = 8'($urandom_range(4, 255));
      v.sc = 8'($urandom_range(4, 255));
      v.mr = (r < 3) ? 4'hF : 4'($urandom);
      v.mk = (r < 3) ? 4'hF : 4'($urandom);
      v.mc = (r < 3) ? 4'hF : 4'($urandom);
      v.has_exp = 1'b0;
      v.exp = '0;
      tbl.push_back(v);
    end

    foreach (tbl[t]) begin
      apply(tbl[t]);
      model_run();
      run_once(tbl[t].name);
      check_mem(tbl[t].name);
      if (tbl[t].has_exp) check_exp(tbl[t]);
    end

    // Abort mid-COMPUTE, then a fresh run must still be exact.
    v = tbl[5];
    v.name = "reset_mid";
    apply(v);
    @(negedge clk); start_reg = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk); resetn = 1'b0; start_reg = 1'b0;
    #1 check("reset_mid done low", int'(done_mat_mul), 0);
    @(negedge clk); resetn = 1'b1;
    seen = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done_mat_mul) seen++;
    end
    check("reset_mid stays idle", seen, 0);
    check_mem("reset_mid no write");
    model_run();
    run_once("reset_mid rerun");
    check_mem("reset_mid rerun");

    // Done holds while start stays high; clear needs start low; rerun must not accumulate.
    v = tbl[1];
    v.name = "b2b";
    apply(v);
    model_run();
    @(negedge clk); start_reg = 1'b1; clear_done_reg = 1'b0;
    @(posedge clk);
    wait_done("b2b run1");
    @(negedge clk); clear_done_reg = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); pe_resetn = 1'b0;
    @(negedge clk); pe_resetn = 1'b1;
    #1 check("b2b done held", int'(done_mat_mul), 1);
    @(negedge clk); start_reg = 1'b0;
    @(posedge clk); #1;
    check("b2b done cleared", int'(done_mat_mul), 0);
    repeat (20) @(posedge clk);
    @(negedge clk); start_reg = 1'b1;
    @(posedge clk);
    wait_done("b2b run2");
    check_mem("b2b run2");
    check_exp(v);
    @(negedge clk); start_reg = 1'b0;
    @(posedge clk); #1;
    check("b2b final clear", int'(done_mat_mul), 0);
    @(negedge clk); clear_done_reg = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
